// File: rtl/scan_doubler.sv
// scan_doubler: ping-pong line buffer that replays each 15 kHz input line twice at full clock rate,
// with optional scanline dimming on the second replay and a 15 kHz bypass path.
module scan_doubler #(
   parameter int ADDR_W = 10,
   parameter int HS_W = 48
) (
   input  logic        clkvideo,
   input  logic        rst,
   input  logic        ce_in,
   input  logic [11:0] rgb_in,
   input  logic        hsync_in,
   input  logic        vsync_in,
   input  logic        enable,
   input  logic        scanlines,
   output logic [11:0] rgb_out,
   output logic        hsync_out,
   output logic        vsync_out
);
   typedef enum logic [1:0] {IDLE, PASS1, PASS2, HOLD} state_t;
   localparam logic [ADDR_W-1:0] X_MAX = '1;
   state_t state, state_n;
   logic hs_q, hs_rise, wr_bank, vs_line, primed, dbl, dbl_n, last;
   logic hs1, act1, dim1, vs1;
   logic [ADDR_W-1:0] wr_x, wa, new_len, line_len, rd_x, rd_x_n;
   logic [11:0] mem [2**(ADDR_W+1)];
   logic [11:0] pix_q, pix;
   assign hs_rise = ce_in & hsync_in & ~hs_q;
   assign wa = hs_rise ? '0 : wr_x;
   // A line that was already in progress at reset has no known start, so it is never replayed.
   assign new_len = primed ? wr_x : '0;
   assign last = rd_x == line_len - 1'b1;
   assign dbl_n = (ce_in & ~enable) ? 1'b0 : (hs_rise & enable) ? 1'b1 : dbl;
   assign pix = (hs1 | ~act1) ? 12'h000 : dim1 ? ((pix_q >> 1) & 12'h777) : pix_q;
   always_ff @(posedge clkvideo) begin
      if (rst) begin
         hs_q <= 1'b0;
         wr_x <= '0;
         wr_bank <= 1'b0;
         line_len <= '0;
         vs_line <= 1'b0;
         primed <= 1'b0;
         dbl <= 1'b1;
      end else begin
         dbl <= dbl_n;
         if (ce_in) hs_q <= hsync_in;
         if (hs_rise) begin
            line_len <= new_len;
            wr_x <= ADDR_W'(1);
            wr_bank <= ~wr_bank;
            vs_line <= vsync_in;
            primed <= 1'b1;
         end else if (ce_in && wr_x != X_MAX) wr_x <= wr_x + 1'b1;
      end
   end
   // The hs_rise pixel belongs to the new line, i.e. the bank that is about to become the write bank.
   always_ff @(posedge clkvideo) begin
      if (ce_in && (hs_rise || wr_x != X_MAX)) mem[{wr_bank ^ hs_rise, wa}] <= rgb_in;
      pix_q <= mem[{~wr_bank, rd_x}];
   end
   always_ff @(posedge clkvideo) begin
      if (rst) begin
         state <= IDLE;
         rd_x <= '0;
      end else begin
         state <= state_n;
         rd_x <= rd_x_n;
      end
   end
   always_comb begin
      state_n = state;
      rd_x_n = rd_x + 1'b1;
      if (hs_rise) begin
         state_n = (new_len != '0) ? PASS1 : IDLE;
         rd_x_n = '0;
      end else if (line_len == '0) begin
         state_n = IDLE;
         rd_x_n = '0;
      end else if (state == IDLE || state == HOLD) rd_x_n = '0;
      else if (last) begin
         state_n = (state == PASS1) ? PASS2 : HOLD;
         rd_x_n = '0;
      end
   end
   // Control travels one stage alongside the buffer read so hsync stays aligned with pixels.
   always_ff @(posedge clkvideo) begin
      if (rst) begin
         hs1 <= 1'b0;
         act1 <= 1'b0;
         dim1 <= 1'b0;
         vs1 <= 1'b0;
      end else begin
         act1 <= state == PASS1 || state == PASS2;
         hs1 <= (state == PASS1 || state == PASS2) && int'(rd_x) < HS_W;
         dim1 <= state == PASS2 && scanlines;
         vs1 <= vs_line;
      end
   end
   always_ff @(posedge clkvideo) begin
      if (rst) begin
         rgb_out <= 12'h000;
         hsync_out <= 1'b0;
         vsync_out <= 1'b0;
      end else if (dbl_n) begin
         rgb_out <= pix;
         hsync_out <= hs1;
         vsync_out <= vs1;
      end else if (ce_in) begin
         rgb_out <= rgb_in;
         hsync_out <= hsync_in;
         vsync_out <= vsync_in;
      end
   end
endmodule

// File: tb/tb_scan_doubler.sv
// tb_scan_doubler: drives a table of input lines and compares every output cycle
// against expectations queued when each line starts.
`timescale 1ns/1ps
module tb_scan_doubler;
   logic clkvideo = 1'b0;
   logic rst, ce_in, hsync_in, vsync_in, enable, scanlines;
   logic [11:0] rgb_in, rgb_out;
   logic hsync_out, vsync_out;
   scan_doubler dut (
      .clkvideo(clkvideo), .rst(rst), .ce_in(ce_in), .rgb_in(rgb_in),
      .hsync_in(hsync_in), .vsync_in(vsync_in), .enable(enable), .scanlines(scanlines),
      .rgb_out(rgb_out), .hsync_out(hsync_out), .vsync_out(vsync_out)
   );
   always #5 clkvideo = ~clkvideo;
   int cyc = 0;
   always @(posedge clkvideo) cyc <= cyc + 1;
   typedef struct {int cyc; logic [11:0] rgb; logic hs; logic vs;} exp_t;
   typedef struct {int len; bit ramp; logic [11:0] p1; logic [11:0] p2; bit sl; bit vs; int stored;} line_t;
   exp_t sb[$];
   exp_t e;
   line_t lines[11];
   int total = 0, bad = 0;
   always @(negedge clkvideo) begin
      if (sb.size() > 0 && sb[0].cyc < cyc) begin
         total++;
         bad++;
         $display("FAIL missed cyc=%0d want rgb=%h", sb[0].cyc, sb[0].rgb);
         void'(sb.pop_front());
      end else if (sb.size() > 0 && sb[0].cyc == cyc) begin
         e = sb.pop_front();
         total++;
         if (rgb_out !== e.rgb) begin
            bad++;
            $display("FAIL rgb_out cyc=%0d got=%h want=%h", cyc, rgb_out, e.rgb);
         end
         total++;
         if (hsync_out !== e.hs) begin
            bad++;
            $display("FAIL hsync_out cyc=%0d got=%b want=%b", cyc, hsync_out, e.hs);
         end
         total++;
         if (vsync_out !== e.vs) begin
            bad++;
            $display("FAIL vsync_out cyc=%0d got=%b want=%b", cyc, vsync_out, e.vs);
         end
      end
   end
   task automatic tick();
      @(posedge clkvideo);
      #1;
   endtask
   task automatic push(int c, logic [11:0] rgb, logic hs, logic vs);
      exp_t x;
      x.cyc = c;
      x.rgb = rgb;
      x.hs = hs;
      x.vs = vs;
      sb.push_back(x);
   endtask
   // Output window opened by line j's hs_rise: replay of line j-1 (two passes, then black) until j+1 starts.
   task automatic push_window(int k, int j);
      int s;
      s = (j > 0) ? lines[j-1].stored : 0;
      for (int m = 0; m < 2 * lines[j].len; m++) begin
         int n;
         logic [11:0] rgb;
         logic hs;
         rgb = 12'h000;
         hs = 1'b0;
         if (m < 2 * s) begin
            n = m % s;
            hs = n < 48;
            if (!hs) rgb = lines[j-1].ramp ? n[11:0] : (m >= s ? lines[j-1].p2 : lines[j-1].p1);
         end
         push(k + 3 + m, rgb, hs, lines[j].vs);
      end
   endtask
   task automatic send_line(int j);
      for (int i = 0; i < lines[j].len; i++) begin
         ce_in = 1'b1;
         hsync_in = i < 8;
         vsync_in = lines[j].vs;
         rgb_in = lines[j].ramp ? i[11:0] : lines[j].p1;
         if (i == 0) push_window(cyc, j);
         tick();
         ce_in = 1'b0;
         rgb_in = 12'($urandom);
         hsync_in = 1'($urandom);
         if (i == 0 && j > 0) scanlines = lines[j-1].sl;
         tick();
      end
   endtask
   initial begin
      lines[0]  = '{320,  1'b1, 12'h000, 12'h000, 1'b0, 1'b1, 320};
      lines[1]  = '{320,  1'b1, 12'h000, 12'h000, 1'b0, 1'b0, 320};
      lines[2]  = '{160,  1'b0, 12'hFFF, 12'h777, 1'b1, 1'b1, 160};
      lines[3]  = '{160,  1'b0, 12'hFFF, 12'hFFF, 1'b0, 1'b0, 160};
      lines[4]  = '{120,  1'b0, 12'h8A1, 12'h450, 1'b1, 1'b0, 120};
      lines[5]  = '{100,  1'b1, 12'h000, 12'h000, 1'b0, 1'b0, 100};
      lines[6]  = '{1100, 1'b1, 12'h000, 12'h000, 1'b0, 1'b1, 1023};
      lines[7]  = '{1040, 1'b1, 12'h000, 12'h000, 1'b0, 1'b0, 1023};
      lines[8]  = '{99,   1'b1, 12'h000, 12'h000, 1'b0, 1'b0, 99};
      lines[9]  = '{70,   1'b0, 12'h3C6, 12'h3C6, 1'b0, 1'b1, 70};
      lines[10] = '{60,   1'b0, 12'h000, 12'h000, 1'b0, 1'b0, 60};
      rst = 1'b1;
      enable = 1'b1;
      scanlines = 1'b0;
      for (int c = 1; c <= 3; c++) push(c, 12'h000, 1'b0, 1'b0);
      for (int c = 0; c < 3; c++) begin
         ce_in = 1'($urandom);
         rgb_in = 12'($urandom);
         hsync_in = 1'($urandom);
         vsync_in = 1'($urandom);
         scanlines = 1'($urandom);
         tick();
      end
      rst = 1'b0;
      scanlines = 1'b0;
      for (int c = 0; c < 50; c++) begin
         push(cyc + 1, 12'h000, 1'b0, 1'b0);
         ce_in = c % 2 == 0;
         hsync_in = 1'b0;
         vsync_in = 1'b0;
         rgb_in = 12'($urandom);
         tick();
      end
      for (int j = 0; j < 11; j++) send_line(j);
      for (int g = 0; g < 5000 && sb.size() > 0; g++) begin
         ce_in = g % 2 == 0;
         hsync_in = 1'b0;
         rgb_in = 12'($urandom);
         tick();
      end
      for (int i = 0; i < 8; i++) begin
         enable = 1'b0;
         ce_in = 1'b1;
         rgb_in = 12'hA5C;
         hsync_in = i[0];
         vsync_in = i[1];
         push(cyc + 1, 12'hA5C, i[0], i[1]);
         push(cyc + 2, 12'hA5C, i[0], i[1]);
         tick();
         ce_in = 1'b0;
         rgb_in = 12'h0F0;
         hsync_in = ~i[0];
         vsync_in = ~i[1];
         tick();
      end
      for (int g = 0; g < 100 && sb.size() > 0; g++) tick();
      tick();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
